// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit holding its tagged result for the CDB; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int VAL_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [2:0]              in_op,
  input  logic [VAL_WIDTH-1:0]    in_rs1,
  input  logic [VAL_WIDTH-1:0]    in_rs2,
  input  logic [ROB_ID_WIDTH:0]   in_lab,
  output logic                    ready,
  output logic                    res_valid,
  output logic [ROB_ID_WIDTH:0]   res_lab,
  output logic [VAL_WIDTH-1:0]    res_val,
  input  logic                    cdb_grant
);
  localparam int W = VAL_WIDTH;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
`ifndef MULDIV_FAST_MUL_EN
  localparam logic [1:0] MUL = 2'd1;
`endif
  logic [1:0] state;
  logic [5:0] cnt;
  logic [2:0] op;
  logic sg1, sg2;
  logic [W-1:0] opb;
  logic [2*W-1:0] acc;
  logic s1, s2, in_sg1, in_sg2, div_zero, div_ovf, done_now;
  logic [W-1:0] mag1, mag2, spec_val, now_val;
  logic [1:0] run_state;
  logic [W:0] div_t, div_d;
  logic [2*W-1:0] nxt, prod;
  logic [W-1:0] dsel, fin;
  logic neg;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_p;
`else
  logic [W:0] mul_sum;
`endif
  assign ready = state == IDLE;
  // Issue-side decode: operand signedness, magnitudes and divide special cases
  always_comb begin
    s1 = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'd1 || in_op[1:0] == 2'd2);
    s2 = in_op[2] ? !in_op[0] : in_op[1:0] == 2'd1;
    in_sg1 = s1 & in_rs1[W-1];
    in_sg2 = s2 & in_rs2[W-1];
    mag1 = in_sg1 ? -in_rs1 : in_rs1;
    mag2 = in_sg2 ? -in_rs2 : in_rs2;
    div_zero = in_op[2] && in_rs2 == '0;
    div_ovf = in_op[2] && !in_op[0] && in_rs1 == {1'b1, {(W-1){1'b0}}} && &in_rs2;
    spec_val = div_zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : {1'b1, {(W-1){1'b0}}});
`ifdef MULDIV_FAST_MUL_EN
    fast_p = {{W{in_sg1}}, in_rs1} * {{W{in_sg2}}, in_rs2};
    done_now = div_zero || div_ovf || !in_op[2];
    now_val = in_op[2] ? spec_val : (in_op[1:0] == 2'd0 ? fast_p[W-1:0] : fast_p[2*W-1:W]);
    run_state = DIV;
`else
    done_now = div_zero || div_ovf;
    now_val = spec_val;
    run_state = in_op[2] ? DIV : MUL;
`endif
  end
  // One iteration step (restoring divide or shift-add multiply) and the sign-corrected final result
  always_comb begin
    div_t = acc[2*W-1:W-1];
    div_d = div_t - {1'b0, opb};
    nxt = div_d[W] ? {div_t[W-1:0], acc[W-2:0], 1'b0} : {div_d[W-1:0], acc[W-2:0], 1'b1};
`ifndef MULDIV_FAST_MUL_EN
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    if (state == MUL) nxt = {mul_sum, acc[W-1:1]};
`endif
    neg = (op[2] && op[1]) ? sg1 : sg1 ^ sg2;
    prod = neg ? -nxt : nxt;
    dsel = op[1] ? nxt[2*W-1:W] : nxt[W-1:0];
    fin = op[2] ? (neg ? -dsel : dsel) : (op[1:0] == 2'd0 ? prod[W-1:0] : prod[2*W-1:W]);
  end
  // FSM, iteration registers and the held result; flush beats accept and grant
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      sg1 <= 1'b0;
      sg2 <= 1'b0;
      opb <= '0;
      acc <= '0;
      res_valid <= 1'b0;
      res_lab <= '0;
      res_val <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        state <= IDLE;
        cnt <= '0;
        res_valid <= 1'b0;
      end else case (state)
        IDLE: if (in_valid) begin
          op <= in_op;
          sg1 <= in_sg1;
          sg2 <= in_sg2;
          res_lab <= in_lab;
          acc <= {{W{1'b0}}, in_op[2] ? mag1 : mag2};
          opb <= in_op[2] ? mag2 : mag1;
          state <= done_now ? DONE : run_state;
          if (done_now) begin
            res_val <= now_val;
            res_valid <= 1'b1;
          end
        end
        DONE: if (cdb_grant) begin
          state <= IDLE;
          res_valid <= 1'b0;
        end
        default: begin
          acc <= nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(W-1)) begin
            cnt <= '0;
            res_val <= fin;
            res_valid <= 1'b1;
            state <= DONE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector bench for muldiv_unit plus backpressure, flush, rdy_in stall and async reset sequences
module tb_muldiv_unit;
  logic clk = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, in_valid = 1'b0, cdb_grant = 1'b0;
  logic [2:0] in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0;
  logic [4:0] in_lab = '0;
  logic ready, res_valid;
  logic [4:0] res_lab;
  logic [31:0] res_val;
  int n_chk = 0, n_fail = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MK = 0;
`else
  localparam int MK = 32;
`endif
  typedef struct {
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] lab;
    logic [31:0] exp;
    int k;
  } vec_t;
  vec_t v[18];

  muldiv_unit dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_lab(in_lab),
    .ready(ready), .res_valid(res_valid), .res_lab(res_lab), .res_val(res_val),
    .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] lab);
    chk("ready_before_issue", 64'(ready), 64'd1);
    in_op = op;
    in_rs1 = a;
    in_rs2 = b;
    in_lab = lab;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!res_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
  endtask

  task automatic grant(input string name);
    cdb_grant = 1'b1;
    @(posedge clk);
    #1 cdb_grant = 1'b0;
    chk({name, "_valid_after_grant"}, 64'(res_valid), 64'd0);
    chk({name, "_ready_after_grant"}, 64'(ready), 64'd1);
  endtask

  task automatic run(input vec_t t, input string name);
    int k;
    issue(t.op, t.a, t.b, t.lab);
    wait_done(0, k);
    chk({name, "_latency"}, 64'(k), 64'(t.k));
    chk({name, "_val"}, 64'(res_val), 64'(t.exp));
    chk({name, "_lab"}, 64'(res_lab), 64'(t.lab));
    chk({name, "_ready_in_done"}, 64'(ready), 64'd0);
    grant(name);
  endtask

  initial begin
    int k;
    bit seen;
    v[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MK};
    v[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, MK};
    v[2]  = '{3'd1, 32'h80000000,   32'h80000000, 5'd2,  32'h40000000, MK};
    v[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, MK};
    v[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD, 32};
    v[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF, 32};
    v[6]  = '{3'd5, 32'd100,        32'd7,        5'd7,  32'd14,       32};
    v[7]  = '{3'd7, 32'd100,        32'd7,        5'd8,  32'd2,        32};
    v[8]  = '{3'd5, 32'd5,          32'd0,        5'd9,  32'hFFFFFFFF, 0};
    v[9]  = '{3'd6, 32'd5,          32'd0,        5'd10, 32'd5,        0};
    v[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000, 0};
    v[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd12, 32'd0,        0};
    v[12] = '{3'd1, 32'hFFFFFFFD,   32'd7,        5'd13, 32'hFFFFFFFF, MK};
    v[13] = '{3'd3, 32'h00010000,   32'h00010000, 5'd14, 32'd1,        MK};
    v[14] = '{3'd5, 32'hFFFFFFFF,   32'h80000001, 5'd15, 32'd1,        32};
    v[15] = '{3'd7, 32'hFFFFFFFF,   32'h80000001, 5'd16, 32'h7FFFFFFE, 32};
    v[16] = '{3'd4, 32'hFFFFFF9C,   32'd7,        5'd17, 32'hFFFFFFF2, 32};
    v[17] = '{3'd6, 32'hFFFFFF9C,   32'd7,        5'd18, 32'hFFFFFFFE, 32};
    #1;
    chk("reset_valid", 64'(res_valid), 64'd0);
    chk("reset_lab", 64'(res_lab), 64'd0);
    chk("reset_val", 64'(res_val), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    #11 rst_in = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) run(v[i], $sformatf("v%0d", i));
    issue(3'd5, 32'd100, 32'd7, 5'd20);
    wait_done(0, k);
    chk("bp_latency", 64'(k), 64'd32);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", i), 64'(res_valid), 64'd1);
      chk($sformatf("bp_hold%0d_val", i), 64'(res_val), 64'd14);
      chk($sformatf("bp_hold%0d_lab", i), 64'(res_lab), 64'd20);
      chk($sformatf("bp_hold%0d_ready", i), 64'(ready), 64'd0);
    end
    grant("bp");
    run(v[7], "bp_next");
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd21);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_valid", 64'(res_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run(v[6], "after_flush");
`ifdef MULDIV_FAST_MUL_EN
    issue(3'd5, 32'd100, 32'd7, 5'd22);
`else
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd22);
`endif
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rdy_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rdy_in = 1'b1;
    wait_done(7, k);
    chk("stall_latency", 64'(k), 64'd35);
`ifdef MULDIV_FAST_MUL_EN
    chk("stall_val", 64'(res_val), 64'd14);
`else
    chk("stall_val", 64'(res_val), 64'hFFFFFFEB);
`endif
    chk("stall_lab", 64'(res_lab), 64'd22);
    grant("stall");
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_in = 1'b1;
    #1;
    chk("async_rst_valid", 64'(res_valid), 64'd0);
    chk("async_rst_lab", 64'(res_lab), 64'd0);
    chk("async_rst_val", 64'(res_val), 64'd0);
    chk("async_rst_ready", 64'(ready), 64'd1);
    #2 rst_in = 1'b0;
    @(posedge clk);
    #1;
    run(v[0], "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
